// File: rtl/isu_pkg.sv
// Shared issue-stage types and helpers for the load/store AGU arbiter.
package isu_pkg;

  localparam int unsigned ROB_SIZE_LOG = 6;
  localparam int unsigned LS_ROBID_W   = ROB_SIZE_LOG + 1;
  localparam int unsigned LS_PAYLOAD_W = 160;

  typedef enum logic [1:0] {
    AGE      = 2'd0,
    FORCE_LD = 2'd1,
    FORCE_ST = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic                    is_store;
    logic [LS_ROBID_W-1:0]   robid;
    logic [LS_PAYLOAD_W-1:0] payload;
  } ls_uop_t;

  // True when robid a is strictly older than b; w is the robid width, its MSB is the wrap bit.
  function automatic logic robid_older(input logic [31:0] a, input logic [31:0] b,
                                       input int unsigned w);
    logic [31:0] mask;
    logic [31:0] ia;
    logic [31:0] ib;
    logic [31:0] wa;
    logic [31:0] wb;
    mask = (32'd1 << (w - 32'd1)) - 32'd1;
    ia   = a & mask;
    ib   = b & mask;
    wa   = a >> (w - 32'd1);
    wb   = b >> (w - 32'd1);
    return (wa[0] == wb[0]) ? (ia < ib) : (ia > ib);
  endfunction

endpackage

// File: rtl/ls_agu_outreg.sv
// One-entry valid/ready output stage feeding the AGU; a kill drops the held uop.
module ls_agu_outreg
  import isu_pkg::*;
#(
  parameter int unsigned ROBID_W   = LS_ROBID_W,
  parameter int unsigned PAYLOAD_W = LS_PAYLOAD_W
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 load_is_store,
  input  logic [ROBID_W-1:0]   load_robid,
  input  logic [PAYLOAD_W-1:0] load_payload,
  input  logic                 kill,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic                 out_is_store,
  output logic [ROBID_W-1:0]   out_robid,
  output logic [PAYLOAD_W-1:0] out_payload
);

  // A new grant wins over kill/drain: the granted request was already screened against the flush.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_is_store <= 1'b0;
      out_robid    <= '0;
      out_payload  <= '0;
    end else if (load) begin
      out_valid    <= 1'b1;
      out_is_store <= load_is_store;
      out_robid    <= load_robid;
      out_payload  <= load_payload;
    end else if (kill || out_ready) begin
      out_valid    <= 1'b0;
    end
  end

endmodule

// File: rtl/ls_agu_arbiter.sv
// Age-ordered load/store arbiter for the shared AGU pipe with starvation override and flush kill.
module ls_agu_arbiter
  import isu_pkg::*;
#(
  parameter int unsigned ROBID_W    = LS_ROBID_W,
  parameter int unsigned PAYLOAD_W  = LS_PAYLOAD_W,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ld_req_valid,
  output logic                 ld_req_ready,
  input  logic [ROBID_W-1:0]   ld_req_robid,
  input  logic [PAYLOAD_W-1:0] ld_req_payload,
  input  logic                 st_req_valid,
  output logic                 st_req_ready,
  input  logic [ROBID_W-1:0]   st_req_robid,
  input  logic [PAYLOAD_W-1:0] st_req_payload,
  output logic                 agu_valid,
  input  logic                 agu_ready,
  output logic                 agu_is_store,
  output logic [ROBID_W-1:0]   agu_robid,
  output logic [PAYLOAD_W-1:0] agu_payload,
  input  logic                 flush_valid,
  input  logic [ROBID_W-1:0]   flush_robid,
  output logic [31:0]          pmu_conflict_cnt,
  output logic [31:0]          pmu_force_cnt
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_SAT = SW'(STARVE_MAX);

  arb_state_e    state, state_nxt;
  logic [SW-1:0] ld_starve, ld_starve_nxt;
  logic [SW-1:0] st_starve, st_starve_nxt;

  logic ld_live, st_live, agu_kill, can_load, ld_older;
  logic grant_ld, grant_st;

  assign ld_live  = ld_req_valid &&
                    !(flush_valid && robid_older(32'(flush_robid), 32'(ld_req_robid), ROBID_W));
  assign st_live  = st_req_valid &&
                    !(flush_valid && robid_older(32'(flush_robid), 32'(st_req_robid), ROBID_W));
  assign agu_kill = flush_valid && agu_valid &&
                    robid_older(32'(flush_robid), 32'(agu_robid), ROBID_W);
  assign can_load = !agu_valid || agu_ready;
  // Equal robids fall through to the store.
  assign ld_older = robid_older(32'(ld_req_robid), 32'(st_req_robid), ROBID_W);

  always_comb begin
    grant_ld = 1'b0;
    grant_st = 1'b0;
    if (can_load && !reset) begin
      unique case (state)
        AGE: begin
          if (ld_live && st_live) begin
            grant_ld = ld_older;
            grant_st = !ld_older;
          end else begin
            grant_ld = ld_live;
            grant_st = st_live;
          end
        end
        FORCE_LD: grant_ld = ld_live;
        FORCE_ST: grant_st = st_live;
        default: ;
      endcase
    end
  end

  assign ld_req_ready = grant_ld;
  assign st_req_ready = grant_st;

  always_comb begin
    ld_starve_nxt = ld_starve;
    if (flush_valid || !ld_req_valid || grant_ld) begin
      ld_starve_nxt = '0;
    end else if (can_load && ld_live && ld_starve != STARVE_SAT) begin
      ld_starve_nxt = ld_starve + SW'(1);
    end

    st_starve_nxt = st_starve;
    if (flush_valid || !st_req_valid || grant_st) begin
      st_starve_nxt = '0;
    end else if (can_load && st_live && st_starve != STARVE_SAT) begin
      st_starve_nxt = st_starve + SW'(1);
    end
  end

  // Force is decided on the post-update count so the starved side wins on the cycle after its last loss.
  always_comb begin
    state_nxt = state;
    unique case (state)
      AGE: begin
        if (ld_starve_nxt == STARVE_SAT)      state_nxt = FORCE_LD;
        else if (st_starve_nxt == STARVE_SAT) state_nxt = FORCE_ST;
      end
      FORCE_LD: if (grant_ld || !ld_live) state_nxt = AGE;
      FORCE_ST: if (grant_st || !st_live) state_nxt = AGE;
      default:  state_nxt = AGE;
    endcase
    if (flush_valid) state_nxt = AGE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= AGE;
      ld_starve        <= '0;
      st_starve        <= '0;
      pmu_conflict_cnt <= '0;
      pmu_force_cnt    <= '0;
    end else begin
      state     <= state_nxt;
      ld_starve <= ld_starve_nxt;
      st_starve <= st_starve_nxt;
      if (ld_live && st_live)
        pmu_conflict_cnt <= pmu_conflict_cnt + 32'd1;
      if ((grant_ld || grant_st) && state != AGE)
        pmu_force_cnt <= pmu_force_cnt + 32'd1;
    end
  end

  ls_agu_outreg #(
    .ROBID_W   (ROBID_W),
    .PAYLOAD_W (PAYLOAD_W)
  ) u_outreg (
    .clock         (clock),
    .reset         (reset),
    .load          (grant_ld || grant_st),
    .load_is_store (grant_st),
    .load_robid    (grant_st ? st_req_robid : ld_req_robid),
    .load_payload  (grant_st ? st_req_payload : ld_req_payload),
    .kill          (agu_kill),
    .out_ready     (agu_ready),
    .out_valid     (agu_valid),
    .out_is_store  (agu_is_store),
    .out_robid     (agu_robid),
    .out_payload   (agu_payload)
  );

endmodule

// File: tb/tb_ls_agu_arbiter.sv
// Directed scoreboard bench for ls_agu_arbiter: expected AGU uops queued at issue, checked at handshake.
module tb_ls_agu_arbiter;
  import isu_pkg::*;

  localparam int unsigned RW = LS_ROBID_W;
  localparam int unsigned PW = LS_PAYLOAD_W;

  logic          clock = 1'b0;
  logic          reset;
  logic          ld_req_valid, ld_req_ready, st_req_valid, st_req_ready;
  logic [RW-1:0] ld_req_robid, st_req_robid, agu_robid, flush_robid;
  logic [PW-1:0] ld_req_payload, st_req_payload, agu_payload;
  logic          agu_valid, agu_ready, agu_is_store, flush_valid;
  logic [31:0]   pmu_conflict_cnt, pmu_force_cnt;

  int unsigned total = 0;
  int unsigned bad   = 0;
  ls_uop_t     exp_q[$];

  ls_agu_arbiter #(
    .ROBID_W    (RW),
    .PAYLOAD_W  (PW),
    .STARVE_MAX (4)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .ld_req_valid     (ld_req_valid),
    .ld_req_ready     (ld_req_ready),
    .ld_req_robid     (ld_req_robid),
    .ld_req_payload   (ld_req_payload),
    .st_req_valid     (st_req_valid),
    .st_req_ready     (st_req_ready),
    .st_req_robid     (st_req_robid),
    .st_req_payload   (st_req_payload),
    .agu_valid        (agu_valid),
    .agu_ready        (agu_ready),
    .agu_is_store     (agu_is_store),
    .agu_robid        (agu_robid),
    .agu_payload      (agu_payload),
    .flush_valid      (flush_valid),
    .flush_robid      (flush_robid),
    .pmu_conflict_cnt (pmu_conflict_cnt),
    .pmu_force_cnt    (pmu_force_cnt)
  );

  always #5 clock = ~clock;

  function automatic logic [PW-1:0] mkpl(input logic [7:0] t);
    return {20{t}};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic s, input logic [RW-1:0] id, input logic [7:0] t);
    ls_uop_t u;
    u.is_store = s;
    u.robid    = id;
    u.payload  = mkpl(t);
    exp_q.push_back(u);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_ld(input logic v, input logic [RW-1:0] id, input logic [7:0] t);
    ld_req_valid   = v;
    ld_req_robid   = id;
    ld_req_payload = mkpl(t);
  endtask

  task automatic drive_st(input logic v, input logic [RW-1:0] id, input logic [7:0] t);
    st_req_valid   = v;
    st_req_robid   = id;
    st_req_payload = mkpl(t);
  endtask

  // Monitor: every AGU handshake must match the oldest queued expectation.
  always @(negedge clock) begin
    ls_uop_t got, exp;
    if (!reset && agu_valid && agu_ready) begin
      got.is_store = agu_is_store;
      got.robid    = agu_robid;
      got.payload  = agu_payload;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL agu_unexpected got=%h exp=none", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          bad++;
          $display("FAIL agu_uop got=%h exp=%h", got, exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    agu_ready = 1'b1;
    flush_valid = 1'b0;
    flush_robid = '0;
    drive_ld(1'b0, '0, 8'h00);
    drive_st(1'b0, '0, 8'h00);
    step();
    step();
    reset = 1'b0;

    // Reset state
    chk("rst_agu_valid", 32'(agu_valid), 32'd0);
    chk("rst_agu_robid", 32'(agu_robid), 32'd0);
    chk("rst_pmu_conf", pmu_conflict_cnt, 32'd0);
    chk("rst_pmu_force", pmu_force_cnt, 32'd0);
    chk("rst_state", 32'(dut.state), 32'(AGE));

    // 1: plain age pick, store older
    drive_ld(1'b1, 7'h05, 8'hA1);
    drive_st(1'b1, 7'h03, 8'hB1);
    #1;
    chk("t1_st_ready", 32'(st_req_ready), 32'd1);
    chk("t1_ld_ready", 32'(ld_req_ready), 32'd0);
    push(1'b1, 7'h03, 8'hB1);
    step();
    drive_ld(1'b0, '0, 8'h00);
    drive_st(1'b0, '0, 8'h00);
    chk("t1_agu_valid", 32'(agu_valid), 32'd1);
    chk("t1_is_store", 32'(agu_is_store), 32'd1);
    chk("t1_robid", 32'(agu_robid), 32'h03);
    step();
    chk("t1_drain", 32'(agu_valid), 32'd0);

    // 2: wrap-bit compare
    drive_ld(1'b1, 7'h41, 8'hA2);
    drive_st(1'b1, 7'h3E, 8'hB2);
    #1;
    chk("t2_st_ready", 32'(st_req_ready), 32'd1);
    chk("t2_ld_ready", 32'(ld_req_ready), 32'd0);
    push(1'b1, 7'h3E, 8'hB2);
    step();
    drive_ld(1'b0, '0, 8'h00);
    drive_st(1'b0, '0, 8'h00);
    step();

    // 3: load starves for four cycles, forced on the fifth
    for (int unsigned k = 0; k < 4; k++) begin
      drive_ld(1'b1, 7'h10, 8'hA3);
      drive_st(1'b1, 7'(8 + k), 8'(8'hC0 + k));
      #1;
      chk("t3_st_win", 32'(st_req_ready), 32'd1);
      push(1'b1, 7'(8 + k), 8'(8'hC0 + k));
      step();
    end
    chk("t3_state_force", 32'(dut.state), 32'(FORCE_LD));
    drive_st(1'b1, 7'h0C, 8'hC4);
    #1;
    chk("t3_ld_forced", 32'(ld_req_ready), 32'd1);
    chk("t3_st_blocked", 32'(st_req_ready), 32'd0);
    push(1'b0, 7'h10, 8'hA3);
    step();
    drive_ld(1'b0, '0, 8'h00);
    drive_st(1'b0, '0, 8'h00);
    chk("t3_pmu_force", pmu_force_cnt, 32'd1);
    chk("t3_state_age", 32'(dut.state), 32'(AGE));
    chk("t3_pmu_conf", pmu_conflict_cnt, 32'd7);
    step();

    // 4: backpressure is not starvation
    agu_ready = 1'b0;
    drive_ld(1'b1, 7'h11, 8'hA4);
    push(1'b0, 7'h11, 8'hA4);
    step();
    drive_ld(1'b1, 7'h12, 8'hA5);
    drive_st(1'b1, 7'h13, 8'hB5);
    for (int unsigned k = 0; k < 3; k++) begin
      #1;
      chk("t4_ld_ready", 32'(ld_req_ready), 32'd0);
      chk("t4_st_ready", 32'(st_req_ready), 32'd0);
      total++;
      if (agu_payload !== mkpl(8'hA4)) begin
        bad++;
        $display("FAIL t4_payload got=%h exp=%h", agu_payload, mkpl(8'hA4));
      end
      step();
      chk("t4_ld_starve", 32'(dut.ld_starve), 32'd0);
      chk("t4_st_starve", 32'(dut.st_starve), 32'd0);
    end
    drive_ld(1'b0, '0, 8'h00);
    drive_st(1'b0, '0, 8'h00);
    agu_ready = 1'b1;
    step();
    chk("t4_drain", 32'(agu_valid), 32'd0);
    chk("t4_pmu_conf", pmu_conflict_cnt, 32'd10);

    // 5: held uop killed by an older flush
    agu_ready = 1'b0;
    drive_ld(1'b1, 7'h20, 8'hA6);
    step();
    drive_ld(1'b0, '0, 8'h00);
    chk("t5_held", 32'(agu_robid), 32'h20);
    flush_valid = 1'b1;
    flush_robid = 7'h1F;
    step();
    flush_valid = 1'b0;
    chk("t5_killed", 32'(agu_valid), 32'd0);

    // 6: flush at the uop's own robid leaves it alive
    drive_ld(1'b1, 7'h20, 8'hA7);
    push(1'b0, 7'h20, 8'hA7);
    step();
    drive_ld(1'b0, '0, 8'h00);
    flush_valid = 1'b1;
    flush_robid = 7'h20;
    step();
    flush_valid = 1'b0;
    chk("t6_survive", 32'(agu_valid), 32'd1);
    chk("t6_robid", 32'(agu_robid), 32'h20);
    agu_ready = 1'b1;
    step();

    // 7: same-cycle flush kills the younger load request only
    flush_valid = 1'b1;
    flush_robid = 7'h08;
    drive_ld(1'b1, 7'h09, 8'hA8);
    drive_st(1'b1, 7'h07, 8'hB8);
    #1;
    chk("t7_st_ready", 32'(st_req_ready), 32'd1);
    chk("t7_ld_ready", 32'(ld_req_ready), 32'd0);
    push(1'b1, 7'h07, 8'hB8);
    step();
    flush_valid = 1'b0;
    drive_ld(1'b0, '0, 8'h00);
    drive_st(1'b0, '0, 8'h00);
    chk("t7_pmu_conf", pmu_conflict_cnt, 32'd10);
    step();

    // 8: reset while the output stage is full
    agu_ready = 1'b0;
    drive_ld(1'b1, 7'h30, 8'hA9);
    step();
    chk("t8_pre_valid", 32'(agu_valid), 32'd1);
    reset = 1'b1;
    agu_ready = 1'b1;
    drive_ld(1'b1, 7'h31, 8'hAA);
    drive_st(1'b1, 7'h32, 8'hBA);
    #1;
    chk("t8_ld_ready", 32'(ld_req_ready), 32'd0);
    chk("t8_st_ready", 32'(st_req_ready), 32'd0);
    step();
    reset = 1'b0;
    drive_ld(1'b0, '0, 8'h00);
    drive_st(1'b0, '0, 8'h00);
    chk("t8_agu_valid", 32'(agu_valid), 32'd0);
    chk("t8_state", 32'(dut.state), 32'(AGE));
    chk("t8_pmu_conf", pmu_conflict_cnt, 32'd0);
    chk("t8_pmu_force", pmu_force_cnt, 32'd0);
    step();
    step();

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
